// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns, FSM state type and nibble arithmetic
// shared by seg7_decoder and seg7_pattern_decode.
package seg7_pkg;

  // Active-low patterns, bit order g..a
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam int FRAME_DIGITS = 6;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    CALC,
    OUT
  } state_t;

  // units + 10*tens + 100*hundreds, wrapping at 7 bits
  function automatic logic [6:0] nibbleSum(
    input logic [3:0] u,
    input logic [3:0] t,
    input logic [3:0] h
  );
    return 7'(u) + 7'(t) * 7'd10 + 7'(h) * 7'd100;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational seven-segment pattern to digit.
// Ports: pattern[6:0] in, digit[3:0] out, legal out.
// SEG7_DECODER_BLANK_EN: all-off pattern is legal and decodes as 0.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       legal
);

  always_comb begin
    digit = 4'd0;
    legal = 1'b1;
    unique case (1'b1)
      pattern == SEG_0: digit = 4'd0;
      pattern == SEG_1: digit = 4'd1;
      pattern == SEG_2: digit = 4'd2;
      pattern == SEG_3: digit = 4'd3;
      pattern == SEG_4: digit = 4'd4;
      pattern == SEG_5: digit = 4'd5;
      pattern == SEG_6: digit = 4'd6;
      pattern == SEG_7: digit = 4'd7;
      pattern == SEG_8: digit = 4'd8;
      pattern == SEG_9: digit = 4'd9;
`ifdef SEG7_DECODER_BLANK_EN
      pattern == SEG_BLANK: digit = 4'd0;
`endif
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_decoder.sv
// seg7_decoder: collects six seven-segment digits and rebuilds a byte.
// Ports: clk, reset_n (async low), seg_in/seg_valid/seg_ready in,
// out_data/out_err/out_valid/out_ready result handshake.
// FRAME_TIMEOUT: idle cycles before a partial frame is dropped (0=off).
// SEG7_DECODER_BLANK_EN: accept the blank pattern as a leading zero.
module seg7_decoder
  import seg7_pkg::*;
#(
  parameter int FRAME_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] seg_in,
  input  logic       seg_valid,
  output logic       seg_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_err
);

  localparam int TW =
    (FRAME_TIMEOUT > 2) ? $clog2(FRAME_TIMEOUT) : 1;
  localparam logic [TW-1:0] IDLE_LAST =
    TW'(FRAME_TIMEOUT - 1);
  localparam bit TO_EN = (FRAME_TIMEOUT != 0);

  state_t        state;
  logic [3:0]    digits [FRAME_DIGITS];
  logic [2:0]    digitCnt;
  logic [TW-1:0] idleCnt;
  logic          errFlag;
  logic [6:0]    lowSum;
  logic [6:0]    highSum;

  logic [3:0] decDigit;
  logic       decLegal;
  logic       accept;
  logic       timeoutHit;
  logic       frameBad;

  seg7_pattern_decode uDecode (
    .pattern (seg_in),
    .digit   (decDigit),
    .legal   (decLegal)
  );

  assign seg_ready = (state == IDLE) || (state == COLLECT);
  assign accept    = seg_valid && seg_ready;

  assign timeoutHit = TO_EN && !accept &&
                      (idleCnt == IDLE_LAST);

  assign frameBad = errFlag ||
                    (lowSum > 7'd15) ||
                    (highSum > 7'd15);

  // Sums are registered in CALC; range check and publish
  // happen on the first OUT cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      digits    <= '{default: '0};
      digitCnt  <= '0;
      idleCnt   <= '0;
      errFlag   <= 1'b0;
      lowSum    <= '0;
      highSum   <= '0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          idleCnt <= '0;
          if (accept) begin
            digits[0] <= decDigit;
            errFlag   <= !decLegal;
            digitCnt  <= 3'd1;
            state     <= COLLECT;
          end
        end
        COLLECT: begin
          if (accept) begin
            digits[digitCnt] <= decDigit;
            if (!decLegal) errFlag <= 1'b1;
            idleCnt <= '0;
            if (digitCnt == 3'(FRAME_DIGITS - 1)) begin
              digitCnt <= '0;
              state    <= CALC;
            end else begin
              digitCnt <= digitCnt + 3'd1;
            end
          end else if (timeoutHit) begin
            digitCnt <= '0;
            idleCnt  <= '0;
            errFlag  <= 1'b0;
            state    <= IDLE;
          end else if (TO_EN) begin
            idleCnt <= idleCnt + 1'b1;
          end
        end
        CALC: begin
          lowSum  <= nibbleSum(digits[0], digits[1], digits[2]);
          highSum <= nibbleSum(digits[3], digits[4], digits[5]);
          state   <= OUT;
        end
        OUT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_err   <= frameBad;
            out_data  <= frameBad ? 8'h00 :
                         {highSum[3:0], lowSum[3:0]};
          end else if (out_ready) begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            out_data  <= 8'h00;
            errFlag   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
